// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the fetched word, registered into a
// two-entry (main + skid) output buffer so ready_in comes straight from a flop.
module decode_stage #(
  parameter int REG_W    = 5,
  parameter int ALU_OP_W = 4,
  parameter int FU_W     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mispredict,
  input  logic                valid_in,
  output logic                ready_in,
  input  logic [31:0]         instr_in,
  input  logic [31:0]         pc_in,
  input  logic [31:0]         pc_4_in,
  output logic                valid_out,
  input  logic                ready_out,
  output logic [31:0]         pc_out,
  output logic [31:0]         pc_4_out,
  output logic [REG_W-1:0]    rs1,
  output logic [REG_W-1:0]    rs2,
  output logic [REG_W-1:0]    rd,
  output logic [31:0]         imm,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [FU_W-1:0]     fu_type,
  output logic                uses_rs1,
  output logic                uses_rs2,
  output logic                writes_rd,
  output logic                is_load,
  output logic                is_store,
  output logic                is_jump,
  output logic                illegal
);

  typedef struct packed {
    logic [31:0]         pc;
    logic [31:0]         pc_4;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [REG_W-1:0]    rd;
    logic [31:0]         imm;
    logic [ALU_OP_W-1:0] alu_op;
    logic [FU_W-1:0]     fu_type;
    logic                uses_rs1;
    logic                uses_rs2;
    logic                writes_rd;
    logic                is_load;
    logic                is_store;
    logic                is_jump;
    logic                illegal;
  } uop_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state, state_next;
  logic   ready_q;
  uop_t   dec, main_q, skid_q;
  logic   load_main_dec, load_main_skid, load_skid_dec;
  logic   accept, out_fire;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_v;
  logic [3:0]  alu_c;
  logic [1:0]  fu_c;
  logic        legal, u1, u2, wr, ld, st, jmp;

  assign opcode = instr_in[6:0];
  assign funct3 = instr_in[14:12];
  assign imm_i  = {{20{instr_in[31]}}, instr_in[31:20]};
  assign imm_s  = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign imm_b  = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25],
                   instr_in[11:8], 1'b0};
  assign imm_u  = {instr_in[31:12], 12'b0};
  assign imm_j  = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20],
                   instr_in[30:21], 1'b0};

  // Class decode; illegal words keep flowing but with every effect stripped.
  always_comb begin
    legal = 1'b1;
    u1    = 1'b0;
    u2    = 1'b0;
    wr    = 1'b0;
    ld    = 1'b0;
    st    = 1'b0;
    jmp   = 1'b0;
    alu_c = 4'd0;
    fu_c  = 2'd0;
    imm_v = 32'd0;
    case (opcode)
      7'b0110111: begin wr = 1'b1; imm_v = imm_u; alu_c = 4'd10; end
      7'b0010111: begin wr = 1'b1; imm_v = imm_u; alu_c = 4'd11; end
      7'b1101111: begin wr = 1'b1; jmp = 1'b1; fu_c = 2'd1; imm_v = imm_j; end
      7'b1100111: begin
        legal = (funct3 == 3'd0);
        u1 = 1'b1; wr = 1'b1; jmp = 1'b1; fu_c = 2'd1; imm_v = imm_i;
      end
      7'b1100011: begin
        legal = (funct3 != 3'd2) && (funct3 != 3'd3);
        u1 = 1'b1; u2 = 1'b1; fu_c = 2'd1; imm_v = imm_b; alu_c = {1'b0, funct3};
      end
      7'b0000011: begin
        legal = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
        u1 = 1'b1; wr = 1'b1; ld = 1'b1; fu_c = 2'd2; imm_v = imm_i; alu_c = {1'b0, funct3};
      end
      7'b0100011: begin
        legal = (funct3 <= 3'd2);
        u1 = 1'b1; u2 = 1'b1; st = 1'b1; fu_c = 2'd2; imm_v = imm_s; alu_c = {1'b0, funct3};
      end
      7'b0010011, 7'b0110011: begin
        u1 = 1'b1;
        wr = 1'b1;
        u2 = opcode[5];
        imm_v = opcode[5] ? 32'd0 : imm_i;
        case (funct3)
          3'd0: alu_c = (opcode[5] && instr_in[30]) ? 4'd1 : 4'd0;
          3'd1: alu_c = 4'd2;
          3'd2: alu_c = 4'd3;
          3'd3: alu_c = 4'd4;
          3'd4: alu_c = 4'd5;
          3'd5: alu_c = instr_in[30] ? 4'd7 : 4'd6;
          3'd6: alu_c = 4'd8;
          default: alu_c = 4'd9;
        endcase
      end
      7'b0001111, 7'b1110011: legal = 1'b1;
      default: legal = 1'b0;
    endcase

    dec           = '0;
    dec.pc        = pc_in;
    dec.pc_4      = pc_4_in;
    dec.illegal   = !legal;
    if (legal) begin
      dec.uses_rs1  = u1;
      dec.uses_rs2  = u2;
      dec.rs1       = u1 ? REG_W'(instr_in[19:15]) : '0;
      dec.rs2       = u2 ? REG_W'(instr_in[24:20]) : '0;
      dec.writes_rd = wr && (instr_in[11:7] != 5'd0);
      dec.rd        = dec.writes_rd ? REG_W'(instr_in[11:7]) : '0;
      dec.imm       = imm_v;
      dec.alu_op    = ALU_OP_W'(alu_c);
      dec.fu_type   = FU_W'(fu_c);
      dec.is_load   = ld;
      dec.is_store  = st;
      dec.is_jump   = jmp;
    end
  end

  assign accept   = valid_in && ready_q;
  assign out_fire = (state != EMPTY) && ready_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_next;
      ready_q <= (state_next != FULL);
    end
  end

  // Skid is always the younger entry, so main refills from skid before any new op.
  always_comb begin
    state_next     = state;
    load_main_dec  = 1'b0;
    load_main_skid = 1'b0;
    load_skid_dec  = 1'b0;
    if (mispredict) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin state_next = ONE; load_main_dec = 1'b1; end
        ONE: begin
          if (accept && out_fire)       load_main_dec = 1'b1;
          else if (accept)              begin state_next = FULL; load_skid_dec = 1'b1; end
          else if (out_fire)            state_next = EMPTY;
        end
        FULL: if (out_fire) begin state_next = ONE; load_main_skid = 1'b1; end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_dec)       main_q <= dec;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid_dec)       skid_q <= dec;
    end
  end

  always_comb begin
    valid_out = (state != EMPTY);
    ready_in  = ready_q;
    pc_out    = main_q.pc;
    pc_4_out  = main_q.pc_4;
    rs1       = main_q.rs1;
    rs2       = main_q.rs2;
    rd        = main_q.rd;
    imm       = main_q.imm;
    alu_op    = main_q.alu_op;
    fu_type   = main_q.fu_type;
    uses_rs1  = main_q.uses_rs1;
    uses_rs2  = main_q.uses_rs2;
    writes_rd = main_q.writes_rd;
    is_load   = main_q.is_load;
    is_store  = main_q.is_store;
    is_jump   = main_q.is_jump;
    illegal   = main_q.illegal;
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table of decode vectors plus handshake corner cases,
// with a scoreboard queue filled on accept and drained on output handshake.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, mispredict, valid_in, ready_out;
  logic [31:0] instr_in, pc_in, pc_4_in;
  logic        ready_in, valid_out;
  logic [31:0] pc_out, pc_4_out, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu_op;
  logic [1:0]  fu_type;
  logic        uses_rs1, uses_rs2, writes_rd, is_load, is_store, is_jump, illegal;

  decode_stage dut (
    .clk(clk), .reset(reset), .mispredict(mispredict),
    .valid_in(valid_in), .ready_in(ready_in), .instr_in(instr_in),
    .pc_in(pc_in), .pc_4_in(pc_4_in), .valid_out(valid_out), .ready_out(ready_out),
    .pc_out(pc_out), .pc_4_out(pc_4_out), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .alu_op(alu_op), .fu_type(fu_type), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
    .writes_rd(writes_rd), .is_load(is_load), .is_store(is_store),
    .is_jump(is_jump), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic [1:0]  fu_type;
    logic [6:0]  flags;
  } op_t;

  typedef struct {
    logic [31:0] instr;
    op_t         exp;
  } vec_t;

  vec_t vecs[15];
  op_t  sb[$];
  op_t  cur_exp;
  int   checks = 0;
  int   errors = 0;
  logic accepted;

  // flags = {uses_rs1, uses_rs2, writes_rd, is_load, is_store, is_jump, illegal}
  function automatic op_t mk(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                             input logic [31:0] im, input logic [3:0] alu,
                             input logic [1:0] fu, input logic [6:0] fl);
    op_t o;
    o = '0;
    o.rs1 = r1; o.rs2 = r2; o.rd = d; o.imm = im; o.alu_op = alu; o.fu_type = fu; o.flags = fl;
    return o;
  endfunction

  function automatic op_t with_pc(input op_t o, input logic [31:0] pc);
    op_t r;
    r = o;
    r.pc = pc;
    r.pc_4 = pc + 32'd4;
    return r;
  endfunction

  function automatic op_t actual();
    op_t o;
    o.pc = pc_out; o.pc_4 = pc_4_out; o.rs1 = rs1; o.rs2 = rs2; o.rd = rd; o.imm = imm;
    o.alu_op = alu_op; o.fu_type = fu_type;
    o.flags = {uses_rs1, uses_rs2, writes_rd, is_load, is_store, is_jump, illegal};
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input op_t exp,
                               input logic [31:0] pc, input logic rdy, input logic mp,
                               input logic rst);
    valid_in   = v;
    instr_in   = ins;
    pc_in      = pc;
    pc_4_in    = pc + 32'd4;
    ready_out  = rdy;
    mispredict = mp;
    reset      = rst;
    cur_exp    = with_pc(exp, pc);
  endtask

  // One clock: observe handshakes at the falling edge, return just after the rising edge.
  task automatic cycle();
    op_t e;
    @(negedge clk);
    accepted = 1'b0;
    if (reset || mispredict) begin
      sb.delete();
    end else begin
      if (valid_out && ready_out) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_output", 128'(actual()), 128'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("out_op", 128'(actual()), 128'(e));
        end
      end
      if (valid_in && ready_in) begin
        accepted = 1'b1;
        sb.push_back(cur_exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sendOp(input int idx, input logic [31:0] pc, input logic rdy);
    int n;
    n = 0;
    applyStimulus(1'b1, vecs[idx].instr, vecs[idx].exp, pc, rdy, 1'b0, 1'b0);
    do begin
      cycle();
      n++;
    end while (!accepted && n < 10);
    checkOutput("accept_timeout", 128'(accepted), 128'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    applyStimulus(1'b0, 32'd0, '0, 32'd0, 1'b1, 1'b0, 1'b0);
    while (sb.size() != 0 && n < 20) begin
      cycle();
      n++;
    end
    checkOutput("drain_empty", 128'(sb.size()), 128'd0);
    cycle();
    checkOutput("drain_valid_out", 128'(valid_out), 128'd0);
  endtask

  initial begin
    vecs[0]  = '{32'h00500093, mk(5'd0, 5'd0, 5'd1, 32'd5,          4'd0,  2'd0, 7'b1010000)};
    vecs[1]  = '{32'hFE000EE3, mk(5'd0, 5'd0, 5'd0, 32'hFFFFFFFC,   4'd0,  2'd1, 7'b1100000)};
    vecs[2]  = '{32'h123452B7, mk(5'd0, 5'd0, 5'd5, 32'h12345000,   4'd10, 2'd0, 7'b0010000)};
    vecs[3]  = '{32'h00000000, mk(5'd0, 5'd0, 5'd0, 32'd0,          4'd0,  2'd0, 7'b0000001)};
    vecs[4]  = '{32'h402081B3, mk(5'd1, 5'd2, 5'd3, 32'd0,          4'd1,  2'd0, 7'b1110000)};
    vecs[5]  = '{32'hFF812303, mk(5'd2, 5'd0, 5'd6, 32'hFFFFFFF8,   4'd2,  2'd2, 7'b1011000)};
    vecs[6]  = '{32'h00712623, mk(5'd2, 5'd7, 5'd0, 32'd12,         4'd2,  2'd2, 7'b1100100)};
    vecs[7]  = '{32'h008000EF, mk(5'd0, 5'd0, 5'd1, 32'd8,          4'd0,  2'd1, 7'b0010010)};
    vecs[8]  = '{32'h00008067, mk(5'd1, 5'd0, 5'd0, 32'd0,          4'd0,  2'd1, 7'b1000010)};
    vecs[9]  = '{32'h40325213, mk(5'd4, 5'd0, 5'd4, 32'h00000403,   4'd7,  2'd0, 7'b1010000)};
    vecs[10] = '{32'h00003003, mk(5'd0, 5'd0, 5'd0, 32'd0,          4'd0,  2'd0, 7'b0000001)};
    vecs[11] = '{32'h0000000F, mk(5'd0, 5'd0, 5'd0, 32'd0,          4'd0,  2'd0, 7'b0000000)};
    vecs[12] = '{32'h00001517, mk(5'd0, 5'd0, 5'd10, 32'h00001000,  4'd11, 2'd0, 7'b0010000)};
    vecs[13] = '{32'h00000013, mk(5'd0, 5'd0, 5'd0, 32'd0,          4'd0,  2'd0, 7'b1000000)};
    vecs[14] = '{32'h00002063, mk(5'd0, 5'd0, 5'd0, 32'd0,          4'd0,  2'd0, 7'b0000001)};

    applyStimulus(1'b0, 32'd0, '0, 32'd0, 1'b0, 1'b0, 1'b1);
    cycle();
    cycle();
    applyStimulus(1'b0, 32'd0, '0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_valid_out", 128'(valid_out), 128'd0);
    checkOutput("reset_ready_in", 128'(ready_in), 128'd1);
    checkOutput("reset_data", 128'(actual()), 128'd0);

    // Table pass, one op per cycle with rename always ready.
    for (int i = 0; i < 15; i++) begin
      sendOp(i, 32'h1000 + 32'(i) * 32'd4, 1'b1);
      if (i == 0) checkOutput("latency_valid_out", 128'(valid_out), 128'd1);
    end
    drain();

    // Back-pressure: A, B fill both slots, C must wait; A stays stable on the output.
    sendOp(4, 32'h2000, 1'b0);
    checkOutput("one_ready_in", 128'(ready_in), 128'd1);
    sendOp(5, 32'h2004, 1'b0);
    checkOutput("full_ready_in", 128'(ready_in), 128'd0);
    applyStimulus(1'b1, vecs[6].instr, vecs[6].exp, 32'h2008, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput("c_held", 128'(accepted), 128'd0);
    checkOutput("stall_valid_out", 128'(valid_out), 128'd1);
    checkOutput("stall_holds_a", 128'(actual()), 128'(with_pc(vecs[4].exp, 32'h2000)));
    sendOp(6, 32'h2008, 1'b1);
    drain();

    // Flush from FULL with an incoming op offered.
    sendOp(7, 32'h3000, 1'b0);
    sendOp(8, 32'h3004, 1'b0);
    applyStimulus(1'b1, vecs[9].instr, vecs[9].exp, 32'h3008, 1'b0, 1'b1, 1'b0);
    cycle();
    checkOutput("flush_full_valid_out", 128'(valid_out), 128'd0);
    checkOutput("flush_full_ready_in", 128'(ready_in), 128'd1);
    drain();

    // Flush from ONE while an op would otherwise be accepted: it must be dropped.
    sendOp(0, 32'h4000, 1'b0);
    applyStimulus(1'b1, vecs[2].instr, vecs[2].exp, 32'h4004, 1'b0, 1'b1, 1'b0);
    cycle();
    checkOutput("flush_one_valid_out", 128'(valid_out), 128'd0);
    drain();

    // Reset while holding one op.
    sendOp(12, 32'h5000, 1'b0);
    applyStimulus(1'b0, 32'd0, '0, 32'd0, 1'b0, 1'b0, 1'b1);
    cycle();
    checkOutput("rst_one_valid_out", 128'(valid_out), 128'd0);
    checkOutput("rst_one_ready_in", 128'(ready_in), 128'd1);
    checkOutput("rst_one_data", 128'(actual()), 128'd0);
    drain();

    // Normal operation resumes after the flushes and reset.
    sendOp(1, 32'h6000, 1'b1);
    sendOp(9, 32'h6004, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
